// File: rtl/branch_ctrl_pkg.sv
// Shared constants for the ID-stage branch controller and the comparator.
package branch_ctrl_pkg;

  localparam logic [5:0] OP_REGIMM = 6'b000001;
  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [5:0] OP_BNE    = 6'b000101;
  localparam logic [5:0] OP_BLEZ   = 6'b000110;
  localparam logic [5:0] OP_BGTZ   = 6'b000111;

  localparam logic [4:0] RT_BLTZ   = 5'b00000;
  localparam logic [4:0] RT_BGEZ   = 5'b00001;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_MEM   = 2'b01;
  localparam logic [1:0] FWD_WB    = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RESOLVE = 2'd2
  } state_t;

  // Branch decode: the four I-type branches plus REGIMM BLTZ/BGEZ.
  function automatic logic is_branch(input logic [5:0] op, input logic [4:0] rt);
    case (op)
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: is_branch = 1'b1;
      OP_REGIMM:                        is_branch = (rt == RT_BLTZ) || (rt == RT_BGEZ);
      default:                          is_branch = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/branch_ctrl_if.sv
// Pipeline-facing signal bundle of the branch controller.
interface branch_ctrl_if;
  logic        id_valid;
  logic [31:0] ins;
  logic [31:0] id_pc4;
  logic        ex_wreg, ex_mem2reg;
  logic [4:0]  ex_rd;
  logic        mem_wreg, mem_mem2reg;
  logic [4:0]  mem_rd;
  logic        wb_wreg;
  logic [4:0]  wb_rd;
  logic        branch;
  logic        cnt_clr;
  logic        compare, stall, pc_sel, flush;
  logic [1:0]  fwd_a, fwd_b;
  logic [31:0] branch_target;
  logic [15:0] br_cnt, taken_cnt;

  modport master (
    output id_valid, ins, id_pc4, ex_wreg, ex_mem2reg, ex_rd,
           mem_wreg, mem_mem2reg, mem_rd, wb_wreg, wb_rd, branch, cnt_clr,
    input  compare, stall, pc_sel, flush, fwd_a, fwd_b, branch_target,
           br_cnt, taken_cnt
  );

  modport slave (
    input  id_valid, ins, id_pc4, ex_wreg, ex_mem2reg, ex_rd,
           mem_wreg, mem_mem2reg, mem_rd, wb_wreg, wb_rd, branch, cnt_clr,
    output compare, stall, pc_sel, flush, fwd_a, fwd_b, branch_target,
           br_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_ctrl_hazard.sv
// Combinational branch decode, stall-need count and operand forwarding select.
module br_hazard
  import branch_ctrl_pkg::*;
(
  input  logic [5:0] op,
  input  logic [4:0] rs,
  input  logic [4:0] rt,
  input  logic       ex_wreg, ex_mem2reg,
  input  logic [4:0] ex_rd,
  input  logic       mem_wreg, mem_mem2reg,
  input  logic [4:0] mem_rd,
  input  logic       wb_wreg,
  input  logic [4:0] wb_rd,
  output logic       is_br,
  output logic [1:0] need,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b
);

  logic [1:0][4:0] src;
  logic [1:0]      used;
  logic [1:0][1:0] nd, fw;

  assign is_br = is_branch(op, rt);
  assign src   = {rt, rs};
  // rt is only a comparator operand for the two-register branches
  assign used  = {(op == OP_BEQ) || (op == OP_BNE), 1'b1};

  for (genvar i = 0; i < 2; i++) begin : g_src
    logic live;
    assign live = used[i] && (src[i] != 5'd0);

    // Stalls needed before this operand can be read or forwarded
    always_comb begin
      nd[i] = 2'd0;
      if (live && ex_wreg && ex_rd == src[i])
        nd[i] = ex_mem2reg ? 2'd2 : 2'd1;
      else if (live && mem_wreg && mem_mem2reg && mem_rd == src[i])
        nd[i] = 2'd1;
    end

    // Forward source; an ALU result in MEM is younger than WB, so it wins
    always_comb begin
      fw[i] = FWD_RF;
      if (live && mem_wreg && !mem_mem2reg && mem_rd == src[i])
        fw[i] = FWD_MEM;
      else if (live && wb_wreg && wb_rd == src[i])
        fw[i] = FWD_WB;
    end
  end

  assign need  = (nd[0] > nd[1]) ? nd[0] : nd[1];
  assign fwd_a = fw[0];
  assign fwd_b = fw[1];

endmodule

// File: rtl/branch_ctrl.sv
// ID-stage branch resolution: stall FSM, compare/redirect control, statistics.
module branch_ctrl
  import branch_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  branch_ctrl_if.slave bif
);

  state_t     state, nxt;
  logic       is_br, go;
  logic [1:0] need, fa, fb;
  logic       cmp, stl;

  br_hazard u_haz (
    .op          (bif.ins[31:26]),
    .rs          (bif.ins[25:21]),
    .rt          (bif.ins[20:16]),
    .ex_wreg     (bif.ex_wreg),
    .ex_mem2reg  (bif.ex_mem2reg),
    .ex_rd       (bif.ex_rd),
    .mem_wreg    (bif.mem_wreg),
    .mem_mem2reg (bif.mem_mem2reg),
    .mem_rd      (bif.mem_rd),
    .wb_wreg     (bif.wb_wreg),
    .wb_rd       (bif.wb_rd),
    .is_br       (is_br),
    .need        (need),
    .fwd_a       (fa),
    .fwd_b       (fb)
  );

  assign go = bif.id_valid && is_br;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= nxt;
  end

  // Next state: stall length follows need; a dropped id_valid aborts
  always_comb begin
    nxt = ST_IDLE;
    case (state)
      ST_IDLE:    if (go) nxt = (need == 2'd2) ? ST_WAIT :
                                (need == 2'd1) ? ST_RESOLVE : ST_IDLE;
      ST_WAIT:    nxt = bif.id_valid ? ST_RESOLVE : ST_IDLE;
      ST_RESOLVE: nxt = ST_IDLE;
      default:    nxt = ST_IDLE;
    endcase
  end

  // Outputs: compare or stall per state, all forced low while in reset
  always_comb begin
    cmp = 1'b0;
    stl = 1'b0;
    case (state)
      ST_IDLE:    if (go) begin
                    cmp = (need == 2'd0);
                    stl = (need != 2'd0);
                  end
      ST_WAIT:    stl = bif.id_valid;
      ST_RESOLVE: cmp = bif.id_valid;
      default:    ;
    endcase
    cmp = cmp && rst_n;
    stl = stl && rst_n;
  end

  assign bif.compare = cmp;
  assign bif.stall   = stl;
  assign bif.pc_sel  = cmp && bif.branch;
  assign bif.flush   = cmp && bif.branch;
  assign bif.fwd_a   = cmp ? fa : FWD_RF;
  assign bif.fwd_b   = cmp ? fb : FWD_RF;

  assign bif.branch_target = bif.id_pc4 + {{14{bif.ins[15]}}, bif.ins[15:0], 2'b00};

  // Saturating statistics; clear beats a same-cycle increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bif.br_cnt    <= 16'd0;
      bif.taken_cnt <= 16'd0;
    end else if (bif.cnt_clr) begin
      bif.br_cnt    <= 16'd0;
      bif.taken_cnt <= 16'd0;
    end else if (cmp) begin
      if (bif.br_cnt != 16'hFFFF) bif.br_cnt <= bif.br_cnt + 16'd1;
      if (bif.branch && bif.taken_cnt != 16'hFFFF) bif.taken_cnt <= bif.taken_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_branch_ctrl.sv
// Directed self-checking bench for branch_ctrl.
module tb_branch_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  int   pass_cnt = 0;
  int   total    = 0;

  branch_ctrl_if bif ();
  branch_ctrl dut (.clk(clk), .rst_n(rst_n), .bif(bif));

  always #5 clk = ~clk;

  // {compare, stall, pc_sel, flush, fwd_a, fwd_b}
  wire [7:0]  outs = {bif.compare, bif.stall, bif.pc_sel, bif.flush, bif.fwd_a, bif.fwd_b};
  wire [31:0] cnts = {bif.br_cnt, bif.taken_cnt};

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_pipe();
    bif.id_valid = 0; bif.ins = 0; bif.id_pc4 = 0; bif.branch = 0; bif.cnt_clr = 0;
    bif.ex_wreg = 0; bif.ex_mem2reg = 0; bif.ex_rd = 0;
    bif.mem_wreg = 0; bif.mem_mem2reg = 0; bif.mem_rd = 0;
    bif.wb_wreg = 0; bif.wb_rd = 0;
  endtask

  task automatic test_reset();
    idle_pipe();
    rst_n = 0;
    bif.id_valid = 1; bif.branch = 1;
    bif.ins = {6'b000100, 5'd1, 5'd2, 16'd4};
    #2;
    if (outs !== 8'h00) $display("FAIL reset_outs: got %b want %b", outs, 8'h00); else pass_cnt++;
    total++;
    tick(); tick();
    if (cnts !== 32'h0) $display("FAIL reset_cnts: got %h want %h", cnts, 32'h0); else pass_cnt++;
    total++;
    bif.id_valid = 0;
    rst_n = 1;
    #1;
  endtask

  task automatic test_beq_nohaz();
    idle_pipe();
    bif.id_valid = 1; bif.branch = 1; bif.id_pc4 = 32'h100;
    bif.ins = {6'b000100, 5'd1, 5'd2, 16'd4};
    #1;
    if (outs !== 8'b1011_0000) $display("FAIL beq_outs: got %b want %b", outs, 8'b1011_0000); else pass_cnt++;
    total++;
    if (bif.branch_target !== 32'h110) $display("FAIL beq_target: got %h want %h", bif.branch_target, 32'h110); else pass_cnt++;
    total++;
    tick();
    bif.id_valid = 0;
    if (cnts !== {16'd1, 16'd1}) $display("FAIL beq_cnts: got %h want %h", cnts, {16'd1, 16'd1}); else pass_cnt++;
    total++;
  endtask

  task automatic test_fwd_same_cycle();
    idle_pipe();
    bif.id_valid = 1; bif.branch = 0;
    bif.ins = {6'b000100, 5'd1, 5'd2, 16'd8};
    bif.mem_wreg = 1; bif.mem_rd = 5'd1;
    bif.wb_wreg = 1; bif.wb_rd = 5'd2;
    #1;
    if (outs !== 8'b1000_0110) $display("FAIL fwd_outs: got %b want %b", outs, 8'b1000_0110); else pass_cnt++;
    total++;
    bif.wb_rd = 5'd1;
    #1;
    if (outs !== 8'b1000_0100) $display("FAIL fwd_mem_prio: got %b want %b", outs, 8'b1000_0100); else pass_cnt++;
    total++;
    tick();
    bif.id_valid = 0;
    if (cnts !== {16'd2, 16'd1}) $display("FAIL fwd_cnts: got %h want %h", cnts, {16'd2, 16'd1}); else pass_cnt++;
    total++;
  endtask

  task automatic test_bne_ex_alu();
    idle_pipe();
    bif.id_valid = 1; bif.branch = 0;
    bif.ins = {6'b000101, 5'd3, 5'd4, 16'd2};
    bif.ex_wreg = 1; bif.ex_rd = 5'd4;
    #1;
    if (outs !== 8'b0100_0000) $display("FAIL bne_stall: got %b want %b", outs, 8'b0100_0000); else pass_cnt++;
    total++;
    tick();
    bif.ex_wreg = 0; bif.ex_rd = 0;
    bif.mem_wreg = 1; bif.mem_rd = 5'd4;
    #1;
    if (outs !== 8'b1000_0001) $display("FAIL bne_resolve: got %b want %b", outs, 8'b1000_0001); else pass_cnt++;
    total++;
    tick();
    bif.id_valid = 0;
    if (cnts !== {16'd3, 16'd1}) $display("FAIL bne_cnts: got %h want %h", cnts, {16'd3, 16'd1}); else pass_cnt++;
    total++;
  endtask

  task automatic test_bgtz_ex_load();
    idle_pipe();
    bif.id_valid = 1; bif.branch = 1;
    bif.ins = {6'b000111, 5'd5, 5'd0, 16'd1};
    bif.ex_wreg = 1; bif.ex_mem2reg = 1; bif.ex_rd = 5'd5;
    #1;
    if (outs !== 8'b0100_0000) $display("FAIL bgtz_stall1: got %b want %b", outs, 8'b0100_0000); else pass_cnt++;
    total++;
    tick();
    bif.ex_wreg = 0; bif.ex_mem2reg = 0; bif.ex_rd = 0;
    bif.mem_wreg = 1; bif.mem_mem2reg = 1; bif.mem_rd = 5'd5;
    #1;
    if (outs !== 8'b0100_0000) $display("FAIL bgtz_stall2: got %b want %b", outs, 8'b0100_0000); else pass_cnt++;
    total++;
    tick();
    bif.mem_wreg = 0; bif.mem_mem2reg = 0; bif.mem_rd = 0;
    bif.wb_wreg = 1; bif.wb_rd = 5'd5;
    #1;
    if (outs !== 8'b1011_1000) $display("FAIL bgtz_resolve: got %b want %b", outs, 8'b1011_1000); else pass_cnt++;
    total++;
    tick();
    bif.id_valid = 0;
    if (cnts !== {16'd4, 16'd2}) $display("FAIL bgtz_cnts: got %h want %h", cnts, {16'd4, 16'd2}); else pass_cnt++;
    total++;
  endtask

  task automatic test_no_stall();
    idle_pipe();
    bif.id_valid = 1;
    bif.ins = {6'b000001, 5'd6, 5'd0, 16'd3};
    bif.ex_wreg = 1; bif.ex_mem2reg = 1; bif.ex_rd = 5'd0;
    #1;
    if (outs !== 8'b1000_0000) $display("FAIL bltz_nostall: got %b want %b", outs, 8'b1000_0000); else pass_cnt++;
    total++;
    tick();
    bif.ins = {6'b000001, 5'd6, 5'd1, 16'd3};
    bif.ex_mem2reg = 0; bif.ex_rd = 5'd1;
    #1;
    if (outs !== 8'b1000_0000) $display("FAIL bgez_nostall: got %b want %b", outs, 8'b1000_0000); else pass_cnt++;
    total++;
    tick();
    bif.id_valid = 0;
    if (cnts !== {16'd6, 16'd2}) $display("FAIL nostall_cnts: got %h want %h", cnts, {16'd6, 16'd2}); else pass_cnt++;
    total++;
  endtask

  task automatic test_target_decode();
    idle_pipe();
    bif.ins = 32'h1000_FFFF; bif.id_pc4 = 32'h4;
    #1;
    if (bif.branch_target !== 32'h0) $display("FAIL target_wrap: got %h want %h", bif.branch_target, 32'h0); else pass_cnt++;
    total++;
    bif.ins = 32'h1000_8000; bif.id_pc4 = 32'h10;
    #1;
    if (bif.branch_target !== 32'hFFFE_0010) $display("FAIL target_neg: got %h want %h", bif.branch_target, 32'hFFFE_0010); else pass_cnt++;
    total++;
    bif.id_valid = 1; bif.branch = 1;
    bif.ins = {6'b000001, 5'd1, 5'd2, 16'd0};
    #1;
    if (outs !== 8'h00) $display("FAIL regimm_rt2: got %b want %b", outs, 8'h00); else pass_cnt++;
    total++;
    tick();
    bif.ins = {6'b000000, 5'd1, 5'd2, 16'd0};
    #1;
    if (outs !== 8'h00) $display("FAIL non_branch: got %b want %b", outs, 8'h00); else pass_cnt++;
    total++;
    tick();
    bif.id_valid = 0;
    if (cnts !== {16'd6, 16'd2}) $display("FAIL decode_cnts: got %h want %h", cnts, {16'd6, 16'd2}); else pass_cnt++;
    total++;
  endtask

  task automatic test_abort();
    idle_pipe();
    bif.id_valid = 1; bif.branch = 1;
    bif.ins = {6'b000111, 5'd5, 5'd0, 16'd1};
    bif.ex_wreg = 1; bif.ex_mem2reg = 1; bif.ex_rd = 5'd5;
    tick();
    bif.id_valid = 0;
    #1;
    if (outs !== 8'h00) $display("FAIL abort_wait: got %b want %b", outs, 8'h00); else pass_cnt++;
    total++;
    tick();
    if (cnts !== {16'd6, 16'd2}) $display("FAIL abort_wait_cnts: got %h want %h", cnts, {16'd6, 16'd2}); else pass_cnt++;
    total++;
    idle_pipe();
    bif.id_valid = 1; bif.branch = 1;
    bif.ins = {6'b000100, 5'd1, 5'd2, 16'd4};
    #1;
    if (outs !== 8'b1011_0000) $display("FAIL abort_back_idle: got %b want %b", outs, 8'b1011_0000); else pass_cnt++;
    total++;
    tick();
    bif.branch = 0;
    bif.ins = {6'b000101, 5'd3, 5'd4, 16'd2};
    bif.ex_wreg = 1; bif.ex_rd = 5'd4;
    tick();
    bif.id_valid = 0;
    #1;
    if (outs !== 8'h00) $display("FAIL abort_resolve: got %b want %b", outs, 8'h00); else pass_cnt++;
    total++;
    tick();
    if (cnts !== {16'd7, 16'd3}) $display("FAIL abort_cnts: got %h want %h", cnts, {16'd7, 16'd3}); else pass_cnt++;
    total++;
  endtask

  task automatic test_reset_mid_stall();
    idle_pipe();
    bif.id_valid = 1; bif.branch = 1;
    bif.ins = {6'b000111, 5'd5, 5'd0, 16'd1};
    bif.ex_wreg = 1; bif.ex_mem2reg = 1; bif.ex_rd = 5'd5;
    tick();
    if (outs !== 8'b0100_0000) $display("FAIL rst_pre_wait: got %b want %b", outs, 8'b0100_0000); else pass_cnt++;
    total++;
    rst_n = 0;
    bif.ex_wreg = 0; bif.ex_mem2reg = 0; bif.ex_rd = 0;
    #1;
    if (outs !== 8'h00) $display("FAIL rst_mid_outs: got %b want %b", outs, 8'h00); else pass_cnt++;
    total++;
    if (cnts !== 32'h0) $display("FAIL rst_mid_cnts: got %h want %h", cnts, 32'h0); else pass_cnt++;
    total++;
    tick();
    bif.id_valid = 0;
    rst_n = 1;
    #1;
    bif.id_valid = 1;
    bif.ins = {6'b000100, 5'd1, 5'd2, 16'd4};
    #1;
    if (outs !== 8'b1011_0000) $display("FAIL rst_then_idle: got %b want %b", outs, 8'b1011_0000); else pass_cnt++;
    total++;
    tick();
    bif.id_valid = 0;
    if (cnts !== {16'd1, 16'd1}) $display("FAIL rst_then_cnts: got %h want %h", cnts, {16'd1, 16'd1}); else pass_cnt++;
    total++;
  endtask

  task automatic test_saturation();
    idle_pipe();
    bif.cnt_clr = 1;
    tick();
    bif.cnt_clr = 0;
    if (cnts !== 32'h0) $display("FAIL clr_only: got %h want %h", cnts, 32'h0); else pass_cnt++;
    total++;
    bif.id_valid = 1; bif.branch = 1;
    bif.ins = {6'b000100, 5'd1, 5'd2, 16'd4};
    repeat (65535) tick();
    if (cnts !== 32'hFFFF_FFFF) $display("FAIL sat_reach: got %h want %h", cnts, 32'hFFFF_FFFF); else pass_cnt++;
    total++;
    tick();
    if (cnts !== 32'hFFFF_FFFF) $display("FAIL sat_hold: got %h want %h", cnts, 32'hFFFF_FFFF); else pass_cnt++;
    total++;
    bif.cnt_clr = 1;
    #1;
    if (outs !== 8'b1011_0000) $display("FAIL clr_with_cmp_outs: got %b want %b", outs, 8'b1011_0000); else pass_cnt++;
    total++;
    tick();
    if (cnts !== 32'h0) $display("FAIL clr_wins: got %h want %h", cnts, 32'h0); else pass_cnt++;
    total++;
    idle_pipe();
  endtask

  initial begin
    test_reset();
    tick();
    test_beq_nohaz();
    test_fwd_same_cycle();
    test_bne_ex_alu();
    test_bgtz_ex_load();
    test_no_stall();
    test_target_decode();
    test_abort();
    test_reset_mid_stall();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
